// File: rtl/common_lib_dispatch_to_one_hot.sv
// Routes one valid/ready stream to one of ONE_HOT_W outputs chosen by a one-hot
// selector; each output owns a small circular FIFO so a stalled output only blocks its own beats.

module common_lib_dispatch_to_one_hot_lane #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             s_rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop_rdy,
  output logic             full,
  output logic             vld,
  output logic [WIDTH-1:0] head
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [PW-1:0]               wptr, rptr;
  logic [CW-1:0]               cnt;
  logic                        pop;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign pop  = vld & pop_rdy;
  assign full = (cnt == CW'(DEPTH));
  assign vld  = (cnt != '0);
  assign head = mem[rptr];

  always_ff @(posedge clk) begin
    if (s_rst) begin
      mem  <= '0;
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= push_data;
        wptr      <= inc(wptr);
      end
      if (pop) rptr <= inc(rptr);
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

module common_lib_dispatch_to_one_hot #(
  parameter int ONE_HOT_W = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 2
) (
  input  logic                                clk,
  input  logic                                s_rst,
  input  logic [ONE_HOT_W-1:0]                in_sel_1h,
  input  logic [WIDTH-1:0]                    in_data,
  input  logic                                in_vld,
  output logic                                in_rdy,
  output logic [ONE_HOT_W-1:0][WIDTH-1:0]     out_data,
  output logic [ONE_HOT_W-1:0]                out_vld,
  input  logic [ONE_HOT_W-1:0]                out_rdy,
  output logic                                err_sel
);
  logic                 legal;
  logic [ONE_HOT_W-1:0] full;
  logic [ONE_HOT_W-1:0] push;

  assign legal = (in_sel_1h != '0) && ((in_sel_1h & (in_sel_1h - 1'b1)) == '0);
  // Illegal beats are always swallowed; legal ones wait only on their own FIFO.
  assign in_rdy = legal ? ~|(in_sel_1h & full) : 1'b1;

  for (genvar i = 0; i < ONE_HOT_W; i++) begin : g_lane
    assign push[i] = in_vld & in_rdy & legal & in_sel_1h[i];

    common_lib_dispatch_to_one_hot_lane #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_lane (
      .clk       (clk),
      .s_rst     (s_rst),
      .push      (push[i]),
      .push_data (in_data),
      .pop_rdy   (out_rdy[i]),
      .full      (full[i]),
      .vld       (out_vld[i]),
      .head      (out_data[i])
    );
  end

  always_ff @(posedge clk) begin
    if (s_rst) err_sel <= 1'b0;
    else       err_sel <= in_vld & ~legal;
  end
endmodule

// File: tb/tb_common_lib_dispatch_to_one_hot.sv
// Directed and scoreboarded checks for the one-hot dispatcher (4 outputs, 8-bit, depth 2).

module tb_common_lib_dispatch_to_one_hot;
  logic             clk = 1'b0;
  logic             s_rst;
  logic [3:0]       in_sel_1h;
  logic [7:0]       in_data;
  logic             in_vld;
  logic             in_rdy;
  logic [3:0][7:0]  out_data;
  logic [3:0]       out_vld;
  logic [3:0]       out_rdy;
  logic             err_sel;

  int n_checks = 0;
  int n_fail   = 0;

  common_lib_dispatch_to_one_hot #(.ONE_HOT_W(4), .WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .s_rst     (s_rst),
    .in_sel_1h (in_sel_1h),
    .in_data   (in_data),
    .in_vld    (in_vld),
    .in_rdy    (in_rdy),
    .out_data  (out_data),
    .out_vld   (out_vld),
    .out_rdy   (out_rdy),
    .err_sel   (err_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    s_rst = 1'b1; in_vld = 1'b0; in_sel_1h = 4'b0001; in_data = 8'h00; out_rdy = 4'b0000;
    tick(); tick();
    s_rst = 1'b0;
    #1;
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL reset_out_vld got %b want 0000", out_vld); end
    n_checks++; if (err_sel !== 1'b0) begin n_fail++; $display("FAIL reset_err_sel got %b want 0", err_sel); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data got %h want 0", out_data); end
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy_legal got %b want 1", in_rdy); end
    in_sel_1h = 4'b0000; #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL reset_in_rdy_illegal got %b want 1", in_rdy); end
  endtask

  task automatic test_single();
    in_sel_1h = 4'b0100; in_data = 8'hA5; in_vld = 1'b1; out_rdy = 4'b1111;
    #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL single_in_rdy got %b want 1", in_rdy); end
    tick();
    in_vld = 1'b0; #1;
    n_checks++; if (out_vld !== 4'b0100) begin n_fail++; $display("FAIL single_out_vld got %b want 0100", out_vld); end
    n_checks++; if (out_data[2] !== 8'hA5) begin n_fail++; $display("FAIL single_out_data got %h want a5", out_data[2]); end
    tick();
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL single_drain got %b want 0000", out_vld); end
  endtask

  task automatic test_backpressure();
    out_rdy = 4'b0000; in_sel_1h = 4'b0001; in_vld = 1'b1; in_data = 8'h11;
    #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy1 got %b want 1", in_rdy); end
    tick();
    in_data = 8'h22; #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy2 got %b want 1", in_rdy); end
    tick();
    in_data = 8'h33; #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_rdy3_full got %b want 0", in_rdy); end
    n_checks++; if (out_data[0] !== 8'h11) begin n_fail++; $display("FAIL bp_head_hold got %h want 11", out_data[0]); end
    tick();
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_still_full got %b want 0", in_rdy); end
    // Popping a full FIFO does not open in_rdy in the same cycle.
    out_rdy = 4'b0001; #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_pop_no_bypass got %b want 0", in_rdy); end
    n_checks++; if (out_data[0] !== 8'h11) begin n_fail++; $display("FAIL bp_first got %h want 11", out_data[0]); end
    tick();
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_rdy_after_pop got %b want 1", in_rdy); end
    n_checks++; if (out_data[0] !== 8'h22) begin n_fail++; $display("FAIL bp_second got %h want 22", out_data[0]); end
    tick();
    in_vld = 1'b0; #1;
    n_checks++; if (out_vld[0] !== 1'b1 || out_data[0] !== 8'h33) begin n_fail++; $display("FAIL bp_third got vld %b data %h want 1 33", out_vld[0], out_data[0]); end
    tick();
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL bp_drain got %b want 0000", out_vld); end
  endtask

  task automatic test_illegal();
    out_rdy = 4'b1111; in_sel_1h = 4'b0000; in_data = 8'hEE; in_vld = 1'b1;
    #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ill_rdy_zero got %b want 1", in_rdy); end
    tick();
    in_sel_1h = 4'b0110; #1;
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL ill_rdy_multi got %b want 1", in_rdy); end
    n_checks++; if (err_sel !== 1'b1) begin n_fail++; $display("FAIL ill_err1 got %b want 1", err_sel); end
    tick();
    in_vld = 1'b0; #1;
    n_checks++; if (err_sel !== 1'b1) begin n_fail++; $display("FAIL ill_err2 got %b want 1", err_sel); end
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL ill_out_vld got %b want 0000", out_vld); end
    tick();
    n_checks++; if (err_sel !== 1'b0) begin n_fail++; $display("FAIL ill_err_end got %b want 0", err_sel); end
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL ill_out_vld2 got %b want 0000", out_vld); end
  endtask

  task automatic test_stream();
    logic [7:0] q[4][$];
    int sent = 0, got = 0, cyc = 0, k = 0;
    logic [7:0] exp;
    in_vld = 1'b0;
    while ((sent < 100 || q[0].size() + q[1].size() + q[2].size() + q[3].size() != 0) && cyc < 2000) begin
      // Hold a stalled beat; otherwise present a fresh one.
      if (!(in_vld && !in_rdy)) begin
        in_vld = (sent < 100) && ($urandom_range(0, 3) != 0);
        k = $urandom_range(0, 3);
        in_sel_1h = 4'b0001 << k;
        in_data = 8'($urandom);
      end
      out_rdy = 4'($urandom);
      #1;
      if (in_vld) begin
        n_checks++;
        if (in_rdy !== (q[k].size() < 2)) begin n_fail++; $display("FAIL stream_in_rdy cyc %0d got %b want %b", cyc, in_rdy, q[k].size() < 2); end
      end
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (out_vld[i] !== (q[i].size() != 0)) begin n_fail++; $display("FAIL stream_vld out %0d cyc %0d got %b want %b", i, cyc, out_vld[i], q[i].size() != 0); end
        if (out_vld[i] && out_rdy[i] && q[i].size() != 0) begin
          exp = q[i].pop_front();
          got++;
          n_checks++;
          if (out_data[i] !== exp) begin n_fail++; $display("FAIL stream_data out %0d cyc %0d got %h want %h", i, cyc, out_data[i], exp); end
        end
      end
      if (in_vld && in_rdy) begin
        q[k].push_back(in_data);
        sent++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_vld = 1'b0;
    n_checks++; if (got !== 100) begin n_fail++; $display("FAIL stream_count got %0d want 100 (cycles %0d)", got, cyc); end
  endtask

  task automatic test_throughput();
    int acc = 0, del = 0;
    out_rdy = 4'b1000; in_sel_1h = 4'b1000;
    for (int c = 0; c < 24; c++) begin
      in_vld = (c < 20);
      in_data = 8'(c);
      #1;
      if (c > 0 && c < 20) begin
        n_checks++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL tput_rdy cyc %0d got %b want 1", c, in_rdy); end
      end
      if (out_vld[3]) begin
        n_checks++;
        if (out_data[3] !== 8'(del)) begin n_fail++; $display("FAIL tput_data got %h want %h", out_data[3], 8'(del)); end
        del++;
      end
      if (in_vld && in_rdy) acc++;
      tick();
    end
    in_vld = 1'b0;
    n_checks++; if (acc !== 20) begin n_fail++; $display("FAIL tput_accepted got %0d want 20", acc); end
    n_checks++; if (del !== 20) begin n_fail++; $display("FAIL tput_delivered got %0d want 20", del); end
  endtask

  task automatic test_reset_mid();
    out_rdy = 4'b0000; in_sel_1h = 4'b0010; in_vld = 1'b1; in_data = 8'hC1;
    tick();
    in_data = 8'hC2;
    tick();
    in_vld = 1'b0; #1;
    n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rmid_full got %b want 0", in_rdy); end
    s_rst = 1'b1;
    tick();
    s_rst = 1'b0; #1;
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL rmid_out_vld got %b want 0000", out_vld); end
    n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rmid_in_rdy got %b want 1", in_rdy); end
    in_data = 8'h5A; in_vld = 1'b1; out_rdy = 4'b0010;
    tick();
    in_vld = 1'b0; #1;
    n_checks++; if (out_vld !== 4'b0010 || out_data[1] !== 8'h5A) begin n_fail++; $display("FAIL rmid_first got vld %b data %h want 0010 5a", out_vld, out_data[1]); end
    tick();
    n_checks++; if (out_vld !== 4'b0000) begin n_fail++; $display("FAIL rmid_drain got %b want 0000", out_vld); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_illegal();
    test_stream();
    test_throughput();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/common_lib_dispatch_to_one_hot.md
# common_lib_dispatch_to_one_hot

Routes a single valid/ready input stream to one of ONE_HOT_W output streams, selected by a per-beat one-hot destination vector. Each output has its own small FIFO, so a stalled destination does not block beats bound for other outputs once they reach the head of the input. It is the distribution counterpart of the one-hot selection mux in common_lib. Typical uses are fanning commands out to parallel processing lanes and returning arbitrated data to its requester.

## Interface
Parameters:
- ONE_HOT_W, 4, number of destinations (>=1)
- WIDTH, 8, data width in bits
- DEPTH, 2, entries per output FIFO (>=2; 2 sustains 1 beat/cycle per output)

Ports:
- clk  in  1  clock; single clock domain
- s_rst  in  1  reset; synchronous and active-high
- in_sel_1h  in  ONE_HOT_W  destination of the current input beat; legal iff exactly one bit set
- in_data  in  WIDTH  input payload
- in_vld  in  1  input beat valid
- in_rdy  out  1  input beat accepted when in_vld & in_rdy
- out_data  out  ONE_HOT_W x WIDTH  per-destination head-of-FIFO payload
- out_vld  out  ONE_HOT_W  per-destination FIFO non-empty
- out_rdy  in  ONE_HOT_W  per-destination pop when out_vld[i] & out_rdy[i]
- err_sel  out  1  one-cycle pulse: an illegal-selector beat was consumed and dropped

## Operation
- Legality: legal = (in_sel_1h != 0) && ((in_sel_1h & (in_sel_1h - 1)) == 0).
- in_rdy is combinational from in_sel_1h and the registered FIFO state:
  - legal selector: in_rdy = ~full[k], where k is the index of the set bit.
  - illegal selector: in_rdy = 1. The beat is consumed, no FIFO is written, and err_sel pulses the next cycle.
- in_rdy never depends on out_rdy in the same cycle. A full FIFO blocks the input even when it is popped that cycle.
- Each output i has a circular FIFO of DEPTH entries:
  - write pointer, read pointer, and occupancy counter of width $clog2(DEPTH+1).
  - full = (cnt == DEPTH), out_vld[i] = (cnt != 0).
  - Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of 2.
- Push and pop on the same FIFO in the same cycle: cnt is unchanged and both pointers advance. This is legal only when not full, per the rule above.
- out_data[i] is the entry at the read pointer, read from registered storage. It is stable while out_vld[i] & ~out_rdy[i].
- Ordering: FIFO order is preserved per destination. No ordering is guaranteed across destinations.
- Input blocking is head-of-line: a beat held for a full destination stalls all subsequent input beats.
- Reset mid-operation: all FIFO contents are discarded and counters and pointers return to 0. No beats are delivered after reset unless they are pushed again.

## Timing
- Reset values:
  - out_vld = 0 and err_sel = 0.
  - in_rdy = 1 for any selector. All FIFOs are empty, so every legal destination is not full and illegal selectors are always ready.
  - out_data = 0 (storage cleared on reset).
- Latency: a beat accepted at edge N appears on out_vld[k]/out_data[k] after edge N (1 cycle) if FIFO k was empty.
- Throughput: 1 beat/cycle into any single destination when that destination pops every cycle and DEPTH >= 2.
- err_sel is registered: it is high for exactly the cycle after each consumed illegal beat. Back-to-back illegal beats give back-to-back pulses.
- out_vld[i] falls the cycle after the pop of the last entry, unless a push to i occurs in the same cycle.

## Test plan
- Reset then single beat: reset held for 2 cycles, then sel=4'b0100, data=0xA5, out_rdy=4'b1111. Required: out_vld=4'b0100 with out_data[2]=0xA5 exactly 1 cycle after acceptance, and out_vld=0 the following cycle.
- Backpressure fill: out_rdy=0 and 3 beats to sel=4'b0001 (data 0x11, 0x22, 0x33). Required: first two beats accepted and in_rdy=0 on the third. After raising out_rdy[0]=1, output order is 0x11, 0x22, 0x33, with 0x33 accepted the cycle after the first pop.
- Illegal selectors: beats with sel=4'b0000 and then 4'b0110. Required: both accepted immediately, err_sel high for 2 consecutive cycles, out_vld stays 0.
- Interleaved streaming: 100 random legal beats with random out_rdy. Required: per-output scoreboard matches in order, and no beat is lost or duplicated.
- Full-throughput: sel fixed to 4'b1000, in_vld=1, out_rdy[3]=1 for 20 cycles. Required: 20 beats accepted and 20 beats delivered, with in_rdy=1 throughout after the first cycle.
- Reset mid-operation: fill output 1 with 2 beats, assert s_rst for 1 cycle. Required: out_vld=0 and in_rdy=1 the cycle after, and the new beat 0x5A to sel=4'b0010 is delivered as the first output.
